writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage that sits in front of the general purpose register file.
- Merges results from the single-cycle ALU and the variable-latency load unit into the register file's single write port (write enable / write address / write data).
- Keeps a 32-entry busy scoreboard so decode can detect RAW hazards before reading operands.

Parameters:
WORD_SIZE, 32, data width of results and register file write data
QUEUE_DEPTH, 4, entries in load-result FIFO; power of 2, >= 2

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
issue_valid  input  1  decode issued an instruction that writes issue_rd
issue_rd  input  5  destination register of issued instruction
alu_valid  input  1  ALU result valid this cycle; always accepted, no backpressure
alu_rd  input  5  ALU destination register
alu_data  input  WORD_SIZE  ALU result
load_valid  input  1  load result offered
load_ready  output  1  load FIFO can accept; transfer when load_valid && load_ready
load_rd  input  5  load destination register
load_data  input  WORD_SIZE  load result
rf_write_enable  output  1  to register file write enable (registered)
rf_write_addr  output  5  to register file write address (registered)
rf_write_data  output  WORD_SIZE  to register file write data (registered)
query_rs1  input  5  decode source register 1
query_rs2  input  5  decode source register 2
rs1_busy  output  1  query_rs1 has a pending write (combinational)
rs2_busy  output  1  query_rs2 has a pending write (combinational)
queue_count  output  $clog2(QUEUE_DEPTH)+1  current load FIFO occupancy

Behaviour:
- Reset (async, reset_n low): rf_write_enable=0, rf_write_addr=0, rf_write_data=0, FIFO emptied (pointers and count 0), scoreboard cleared. queue_count=0, load_ready=1, rs*_busy=0.
- load_ready = (queue_count != QUEUE_DEPTH); depends only on count. A full FIFO stays not-ready even in a cycle where it pops.
- FIFO push when load_valid && load_ready. Circular pointers wrap modulo QUEUE_DEPTH. Simultaneous push and pop leaves count unchanged.
- Arbitration each rising edge, fixed priority:
  - If alu_valid, the ALU result is selected.
  - Else if FIFO is non-empty, the FIFO head is selected and popped.
  - Else nothing is selected; rf_write_enable=0 next cycle and addr/data hold their previous values.
- Latency:
  - ALU result appears on the rf_write_* outputs on the edge after alu_valid (1 cycle).
  - A load result pushed into an empty FIFO with no ALU traffic appears 2 edges after acceptance: push edge, then pop edge.
- Loads starve while the ALU is valid every cycle; this is permitted. The FIFO fills and load_ready backpressures the load unit.
- Writes to rd=0 are dropped: the entry is consumed or popped normally but rf_write_enable stays 0 that cycle.
- Scoreboard: busy[31:0], bit 0 hardwired 0.
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd].
  - Clear: busy[rd] clears on the edge where rf_write_enable is driven high for rd.
  - Same-edge set and clear of the same rd: set wins.
- Decode must not issue to an rd that is already busy (no WAW tracking). If it does, the bit stays set and the first write clears it.
- rsN_busy = busy[query_rsN]; query of 0 always returns 0.
- Reset mid-operation discards queued loads and pending scoreboard bits. Any rf write registered before reset asserted is cancelled: rf_write_enable drops immediately.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, adds outputs rs1_fwd_valid (1), rs1_fwd_data (WORD_SIZE), rs2_fwd_valid (1), rs2_fwd_data (WORD_SIZE).
  - rsN_fwd_valid = rf_write_enable && rf_write_addr==query_rsN && query_rsN!=0.
  - rsN_fwd_data = rf_write_data.
  - This lets decode take the value being written this cycle instead of stalling.
  - All four outputs are 0 during reset.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then ALU: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle rf_write_enable=1, addr=5, data=0xDEADBEEF; following cycle enable=0.
- Scoreboard: issue rd=7, query_rs1=7 -> rs1_busy=1 from the next edge until the edge rf_write_enable fires for rd 7, then 0. Query of 0 is always 0.
- Priority and starvation:
  - ALU valid 6 consecutive cycles (rd 1..6) while loads rd=10..14 are offered.
  - Required response: load_ready drops after 4 accepts with queue_count=4; ALU writes 1..6 occur in order.
  - Then loads 10..13 are written in FIFO order, then load 14 is accepted and written.
- x0 drop: alu_rd=0, data=0x1234 -> rf_write_enable stays 0; a load with rd=0 pops the FIFO (count decrements) without a write.
- Same-edge set/clear: ALU write to rd=9 retiring while issue_valid, issue_rd=9 -> busy[9]=1 afterwards.
- Mid-operation reset: FIFO holding 3 entries, busy bits set, reset_n pulsed low between edges -> queue_count=0, rf_write_enable=0 immediately, all busy=0, load_ready=1. With WB_BYPASS_EN defined: write rd=3 with query_rs2=3 -> rs2_fwd_valid=1 and rs2_fwd_data equals the write data that cycle.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU and load results onto the register-file write port
// and tracks pending destination registers. Optional forwarding outputs: WB_BYPASS_EN.
module writeback_unit #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [WORD_SIZE-1:0]          alu_data,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [4:0]                    load_rd,
    input  logic [WORD_SIZE-1:0]          load_data,
    output logic                          rf_write_enable,
    output logic [4:0]                    rf_write_addr,
    output logic [WORD_SIZE-1:0]          rf_write_data,
    input  logic [4:0]                    query_rs1,
    input  logic [4:0]                    query_rs2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
`ifdef WB_BYPASS_EN
    ,
    output logic                          rs1_fwd_valid,
    output logic [WORD_SIZE-1:0]          rs1_fwd_data,
    output logic                          rs2_fwd_valid,
    output logic [WORD_SIZE-1:0]          rs2_fwd_data
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]           fifo_rd_q   [QUEUE_DEPTH];
    logic [4:0]           fifo_rd_d   [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0] fifo_data_q [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0] fifo_data_d [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 rf_we_q, rf_we_d;
    logic [4:0]           rf_addr_q, rf_addr_d;
    logic [WORD_SIZE-1:0] rf_data_q, rf_data_d;
    logic [31:0]          busy_q, busy_d;

    logic                 push;
    logic                 pop;
    logic                 sel_valid;
    logic [4:0]           sel_rd;
    logic [WORD_SIZE-1:0] sel_data;

    // Readiness looks only at the registered count, so a full FIFO stays
    // not-ready even on a cycle where it also pops.
    assign load_ready = (count_q != CNT_W'(QUEUE_DEPTH));
    assign push       = load_valid && load_ready;
    assign pop        = !alu_valid && (count_q != '0);

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = load_rd;
            fifo_data_d[wr_ptr_q] = load_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Writes to x0 are consumed but never reach the register file; address
    // and data only move when a real write happens.
    always_comb begin
        rf_we_d   = sel_valid && (sel_rd != '0);
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (rf_we_d) begin
            rf_addr_d = sel_rd;
            rf_data_d = sel_data;
        end
    end

    // Set is applied after clear so a same-edge issue to a retiring rd wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_d) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign rf_write_enable = rf_we_q;
    assign rf_write_addr   = rf_addr_q;
    assign rf_write_data   = rf_data_q;
    assign rs1_busy        = busy_q[query_rs1];
    assign rs2_busy        = busy_q[query_rs2];
    assign queue_count     = count_q;

`ifdef WB_BYPASS_EN
    assign rs1_fwd_valid = rf_we_q && (rf_addr_q == query_rs1) && (query_rs1 != '0);
    assign rs2_fwd_valid = rf_we_q && (rf_addr_q == query_rs2) && (query_rs2 != '0);
    assign rs1_fwd_data  = rf_data_q;
    assign rs2_fwd_data  = rf_data_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU path, scoreboard, priority,
// x0 drop, same-edge set/clear, mid-operation reset, optional forwarding.
module tb_writeback_unit;

    localparam int unsigned WS = 32;
    localparam int unsigned QD = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [WS-1:0] alu_data;
    logic          load_valid;
    logic          load_ready;
    logic [4:0]    load_rd;
    logic [WS-1:0] load_data;
    logic          rf_write_enable;
    logic [4:0]    rf_write_addr;
    logic [WS-1:0] rf_write_data;
    logic [4:0]    query_rs1;
    logic [4:0]    query_rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [2:0]    queue_count;
`ifdef WB_BYPASS_EN
    logic          rs1_fwd_valid;
    logic [WS-1:0] rs1_fwd_data;
    logic          rs2_fwd_valid;
    logic [WS-1:0] rs2_fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    writeback_unit #(.WORD_SIZE(WS), .QUEUE_DEPTH(QD)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_rd(load_rd), .load_data(load_data),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .queue_count(queue_count)
`ifdef WB_BYPASS_EN
        ,
        .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", rf_write_enable); end
        n_checks++; if (rf_write_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", rf_write_addr); end
        n_checks++; if (rf_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", rf_write_data); end
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", queue_count); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", load_ready); end
        n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rs1_busy); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL idle_we got %b want 0", rf_write_enable); end
    endtask

    task automatic test_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (rf_write_enable !== 1'b1) begin n_fail++; $display("FAIL alu_we got %b want 1", rf_write_enable); end
        n_checks++; if (rf_write_addr !== 5'd5) begin n_fail++; $display("FAIL alu_addr got %0d want 5", rf_write_addr); end
        n_checks++; if (rf_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data got %h want deadbeef", rf_write_data); end
        tick();
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop got %b want 0", rf_write_enable); end
        n_checks++; if (rf_write_addr !== 5'd5) begin n_fail++; $display("FAIL alu_addr_hold got %0d want 5", rf_write_addr); end
        n_checks++; if (rf_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data_hold got %h want deadbeef", rf_write_data); end
    endtask

    task automatic test_scoreboard;
        query_rs1 = 5'd7; query_rs2 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_pre got %b want 0", rs1_busy); end
        tick();
        issue_valid = 1'b0;
        n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b want 1", rs1_busy); end
        tick();
        n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_hold got %b want 1", rs1_busy); end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd7) begin n_fail++; $display("FAIL sb_write got we=%b addr=%0d want we=1 addr=7", rf_write_enable, rf_write_addr); end
        n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_clear got %b want 0", rs1_busy); end
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_x0 got %b want 0", rs2_busy); end
    endtask

    task automatic test_priority_starvation;
        logic [4:0] exp_rd [5];
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'h100 + 32'(i + 1);
            load_valid = 1'b1;
            load_rd = 5'(10 + ((i < 4) ? i : 4));
            load_data = 32'hA00 + 32'(load_rd);
            #1;
            n_checks++; if (load_ready !== (i < 4)) begin n_fail++; $display("FAIL starve_ready[%0d] got %b want %b", i, load_ready, (i < 4)); end
            tick();
            n_checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'(i + 1) || rf_write_data !== 32'h100 + 32'(i + 1))
                begin n_fail++; $display("FAIL starve_alu[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", i, rf_write_enable, rf_write_addr, rf_write_data, i + 1, 32'h100 + 32'(i + 1)); end
            n_checks++; if (queue_count !== 3'((i < 3) ? i + 1 : 4)) begin n_fail++; $display("FAIL starve_count[%0d] got %0d want %0d", i, queue_count, (i < 3) ? i + 1 : 4); end
        end
        alu_valid = 1'b0;
        exp_rd = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        for (int j = 0; j < 5; j++) begin
            load_valid = (j < 2);
            #1;
            if (j == 0) begin
                n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL drain_full_ready got %b want 0", load_ready); end
            end
            tick();
            n_checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== exp_rd[j] || rf_write_data !== 32'hA00 + 32'(exp_rd[j]))
                begin n_fail++; $display("FAIL drain_write[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", j, rf_write_enable, rf_write_addr, rf_write_data, exp_rd[j], 32'hA00 + 32'(exp_rd[j])); end
            n_checks++; if (queue_count !== 3'((j < 2) ? 3 : 4 - j)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", j, queue_count, (j < 2) ? 3 : 4 - j); end
        end
        tick();
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL drain_idle got %b want 0", rf_write_enable); end
    endtask

    task automatic test_x0_drop;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        tick();
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL x0_alu got %b want 0", rf_write_enable); end
        alu_rd = 5'd2; alu_data = 32'h2222;
        load_valid = 1'b1; load_rd = 5'd0; load_data = 32'h5555;
        tick();
        alu_valid = 1'b0; load_valid = 1'b0;
        n_checks++; if (queue_count !== 3'd1) begin n_fail++; $display("FAIL x0_push_count got %0d want 1", queue_count); end
        n_checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd2) begin n_fail++; $display("FAIL x0_alu2 got we=%b addr=%0d want we=1 addr=2", rf_write_enable, rf_write_addr); end
        tick();
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL x0_pop_count got %0d want 0", queue_count); end
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL x0_load got %b want 0", rf_write_enable); end
    endtask

    task automatic test_same_edge;
        query_rs1 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        issue_valid = 1'b0;
        n_checks++; if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd9) begin n_fail++; $display("FAIL same_write got we=%b addr=%0d want we=1 addr=9", rf_write_enable, rf_write_addr); end
        n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL same_setwins got %b want 1", rs1_busy); end
        tick();
        alu_valid = 1'b0;
        n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL same_cleared got %b want 0", rs1_busy); end
    endtask

    task automatic test_mid_reset;
        query_rs1 = 5'd25; query_rs2 = 5'd26;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'(i);
            load_valid = 1'b1; load_rd = 5'(21 + i); load_data = 32'hB0 + 32'(i);
            issue_valid = (i < 2); issue_rd = 5'(25 + i);
            tick();
        end
        issue_valid = 1'b0; load_valid = 1'b0;
        n_checks++; if (queue_count !== 3'd3 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || rf_write_enable !== 1'b1)
            begin n_fail++; $display("FAIL mr_pre got count=%0d b1=%b b2=%b we=%b want count=3 b1=1 b2=1 we=1", queue_count, rs1_busy, rs2_busy, rf_write_enable); end
        alu_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL mr_count got %0d want 0", queue_count); end
        n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL mr_we got %b want 0", rf_write_enable); end
        n_checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got %b%b want 00", rs1_busy, rs2_busy); end
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready got %b want 1", load_ready); end
`ifdef WB_BYPASS_EN
        n_checks++; if (rs1_fwd_valid !== 1'b0 || rs2_fwd_valid !== 1'b0 || rs1_fwd_data !== '0 || rs2_fwd_data !== '0)
            begin n_fail++; $display("FAIL mr_fwd got v=%b%b want 00 and zero data", rs1_fwd_valid, rs2_fwd_valid); end
`endif
        #2;
        reset_n = 1'b1;
        tick();
        n_checks++; if (rf_write_enable !== 1'b0 || queue_count !== 3'd0) begin n_fail++; $display("FAIL mr_after got we=%b count=%0d want we=0 count=0", rf_write_enable, queue_count); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass;
        query_rs1 = 5'd9; query_rs2 = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_CAFE;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (rs2_fwd_valid !== 1'b1 || rs2_fwd_data !== 32'h3333_CAFE) begin n_fail++; $display("FAIL byp_rs2 got v=%b d=%h want v=1 d=3333cafe", rs2_fwd_valid, rs2_fwd_data); end
        n_checks++; if (rs1_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL byp_rs1 got %b want 0", rs1_fwd_valid); end
        tick();
        n_checks++; if (rs2_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL byp_idle got %b want 0", rs2_fwd_valid); end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        load_valid = 1'b0; load_rd = '0; load_data = '0;
        query_rs1 = 5'd7; query_rs2 = '0;
        test_reset();
        test_alu();
        test_scoreboard();
        test_priority_starvation();
        test_x0_drop();
        test_same_edge();
        test_mid_reset();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
